// File: rtl/time_stamp_capture_ctrl_pkg.sv
// Shared types and constants for the timestamp capture controller.
package time_stamp_capture_ctrl_pkg;

    localparam int TS_DWIDTH_DEF = 64;
    localparam int MAX_NUM_REQ   = 16;

    typedef logic [TS_DWIDTH_DEF-1:0]       ts_t;
    typedef logic [$clog2(MAX_NUM_REQ)-1:0] req_idx_t;

    // Round-robin successor of a requester index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/time_stamp_capture_ctrl_arbiter.sv
// Round-robin arbiter over the pending holding slots; pointer advances only
// when the output register actually takes a grant.
module ts_rr_arbiter
    import time_stamp_capture_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] request,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] ptr;
    int               cand;

    // First pending slot at or after ptr, wrapping.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_valid && request[IDX_W'(cand)]) begin
                grant_valid            = 1'b1;
                grant[IDX_W'(cand)]    = 1'b1;
                grant_idx              = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (advance && grant_valid)
            ptr <= IDX_W'(rr_next(int'(grant_idx), NUM_REQ));
    end

endmodule

// File: rtl/time_stamp_capture_ctrl.sv
// Free-running timestamp counter with per-requester capture slots drained
// round-robin onto a valid/ready stream. TS_CTRL_DROP_CNT_EN adds drop counters.
module time_stamp_capture_ctrl
    import time_stamp_capture_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TS_DWIDTH      = TS_DWIDTH_DEF,
    parameter int DROP_CNT_WIDTH = 16,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cnt_en,
    input  logic                               cnt_load,
    input  logic [TS_DWIDTH-1:0]               cnt_load_val,
    output logic [TS_DWIDTH-1:0]               cur_time,
    input  logic [NUM_REQ-1:0]                 req,
    output logic [TS_DWIDTH-1:0]               ts_data,
    output logic [IDX_W-1:0]                   ts_src,
    output logic                               ts_valid,
    input  logic                               ts_ready,
    output logic [NUM_REQ-1:0]                 pending,
    output logic [NUM_REQ-1:0]                 overflow,
`ifdef TS_CTRL_DROP_CNT_EN
    output logic [NUM_REQ*DROP_CNT_WIDTH-1:0]  drop_cnt,
`endif
    input  logic                               ovf_clr
);

    logic [NUM_REQ-1:0][TS_DWIDTH-1:0] slot_ts;
    logic [NUM_REQ-1:0]                grant;
    logic [IDX_W-1:0]                  grant_idx;
    logic                              grant_valid;
    logic                              load_out;

    always_ff @(posedge clk) begin
        if (reset)
            cur_time <= '0;
        else if (cnt_load)
            cur_time <= cnt_load_val;
        else if (cnt_en)
            cur_time <= cur_time + 1'b1;
    end

    assign load_out = !ts_valid || ts_ready;

    ts_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .request     (pending),
        .advance     (load_out),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

`ifdef TS_CTRL_DROP_CNT_EN
    logic [NUM_REQ-1:0][DROP_CNT_WIDTH-1:0] drop_q;
    assign drop_cnt = drop_q;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        logic                 take;
        logic                 drop;
        logic                 pend_q;
        logic                 ovf_q;
        logic [TS_DWIDTH-1:0] ts_q;

        assign take = load_out && grant[i];
        // A slot drained on this edge can accept a new capture without loss.
        assign drop = req[i] && pend_q && !take;

        always_ff @(posedge clk) begin
            if (reset) begin
                ts_q   <= '0;
                pend_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                if (req[i] && (!pend_q || take)) begin
                    ts_q   <= cur_time;
                    pend_q <= 1'b1;
                end else if (take) begin
                    pend_q <= 1'b0;
                end
                if (ovf_clr)
                    ovf_q <= 1'b0;
                else if (drop)
                    ovf_q <= 1'b1;
            end
        end

`ifdef TS_CTRL_DROP_CNT_EN
        always_ff @(posedge clk) begin
            if (reset || ovf_clr)
                drop_q[i] <= '0;
            else if (drop && drop_q[i] != '1)
                drop_q[i] <= drop_q[i] + 1'b1;
        end
`endif

        assign slot_ts[i]  = ts_q;
        assign pending[i]  = pend_q;
        assign overflow[i] = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_data  <= '0;
            ts_src   <= '0;
            ts_valid <= 1'b0;
        end else if (load_out) begin
            ts_valid <= grant_valid;
            if (grant_valid) begin
                ts_data <= slot_ts[grant_idx];
                ts_src  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_time_stamp_capture_ctrl.sv
// Directed self-checking bench for time_stamp_capture_ctrl (4 requesters,
// 64-bit timestamps); drop counter checks follow TS_CTRL_DROP_CNT_EN.
module tb_time_stamp_capture_ctrl;
    import time_stamp_capture_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cnt_en;
    logic          cnt_load;
    ts_t           cnt_load_val;
    ts_t           cur_time;
    logic [N-1:0]  req;
    ts_t           ts_data;
    logic [1:0]    ts_src;
    logic          ts_valid;
    logic          ts_ready;
    logic [N-1:0]  pending;
    logic [N-1:0]  overflow;
    logic          ovf_clr;
`ifdef TS_CTRL_DROP_CNT_EN
    logic [N*DW-1:0] drop_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    time_stamp_capture_ctrl #(
        .NUM_REQ        (N),
        .TS_DWIDTH      (64),
        .DROP_CNT_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cnt_en       (cnt_en),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cur_time     (cur_time),
        .req          (req),
        .ts_data      (ts_data),
        .ts_src       (ts_src),
        .ts_valid     (ts_valid),
        .ts_ready     (ts_ready),
        .pending      (pending),
        .overflow     (overflow),
`ifdef TS_CTRL_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input ts_t v);
        cnt_load = 1'b1;
        cnt_load_val = v;
        cyc();
        cnt_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cnt_en = 1'b0; cnt_load = 1'b0; cnt_load_val = '0;
        req = '0; ts_ready = 1'b0; ovf_clr = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_cur_time", cur_time, 0);
        chk("rst_ts_valid", 64'(ts_valid), 0);
        chk("rst_ts_data", ts_data, 0);
        chk("rst_ts_src", 64'(ts_src), 0);
        chk("rst_pending", 64'(pending), 0);
        chk("rst_overflow", 64'(overflow), 0);
`ifdef TS_CTRL_DROP_CNT_EN
        chk("rst_drop_cnt", 64'(drop_cnt), 0);
`endif

        // Counter control
        cnt_en = 1'b1;
        repeat (10) cyc();
        cnt_en = 1'b0;
        chk("cnt_run10", cur_time, 10);
        repeat (3) cyc();
        chk("cnt_hold", cur_time, 10);
        load(64'hFFFF_FFFF_FFFF_FFFE);
        chk("cnt_load", cur_time, 64'hFFFF_FFFF_FFFF_FFFE);
        cnt_en = 1'b1;
        cyc(); chk("cnt_allones", cur_time, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(); chk("cnt_wrap0", cur_time, 0);
        cyc(); chk("cnt_wrap1", cur_time, 1);

        // Single capture while counting: pre-increment value is taken
        load(100);
        ts_ready = 1'b1;
        req = 4'b0100;
        cyc();
        req = '0;
        chk("single_pend", 64'(pending), 64'b0100);
        chk("single_nvalid", 64'(ts_valid), 0);
        cyc();
        chk("single_valid", 64'(ts_valid), 1);
        chk("single_data", ts_data, 100);
        chk("single_src", 64'(ts_src), 2);
        chk("single_pend_clr", 64'(pending), 0);
        cyc();
        chk("single_drained", 64'(ts_valid), 0);
        cnt_en = 1'b0;

        // Simultaneous requests from a fresh pointer
        reset = 1'b1; cyc(); reset = 1'b0;
        load(50);
        req = 4'b1111;
        cyc();
        req = '0;
        chk("sim_pend", 64'(pending), 64'b1111);
        for (int k = 0; k < N; k++) begin
            cyc();
            chk("sim_valid", 64'(ts_valid), 1);
            chk("sim_data", ts_data, 50);
            chk("sim_src", 64'(ts_src), 64'(k));
        end
        cyc();
        chk("sim_drained", 64'(ts_valid), 0);
        req = 4'b0011;
        cyc();
        req = '0;
        cyc(); chk("rr2_src0", 64'(ts_src), 0);
        cyc(); chk("rr2_src1", 64'(ts_src), 1);
        cyc(); chk("rr2_drained", 64'(ts_valid), 0);

        // Backpressure and overflow
        ts_ready = 1'b0;
        load(20);
        req = 4'b0010; cyc(); req = '0;
        cyc();
        chk("bp_out20", ts_data, 20);
        chk("bp_out_src", 64'(ts_src), 1);
        chk("bp_slot_free", 64'(pending), 0);
        load(25);
        // Capture coincides with a load: pre-load value 25 is kept
        req = 4'b0010; cnt_load = 1'b1; cnt_load_val = 30;
        cyc();
        req = '0; cnt_load = 1'b0;
        chk("bp_cur30", cur_time, 30);
        chk("bp_pend1", 64'(pending), 64'b0010);
        req = 4'b0010; cyc(); req = '0;
        chk("bp_ovf", 64'(overflow), 64'b0010);
        chk("bp_hold_data", ts_data, 20);
        chk("bp_hold_valid", 64'(ts_valid), 1);
`ifdef TS_CTRL_DROP_CNT_EN
        chk("bp_drop1", 64'(drop_cnt[2*DW-1:DW]), 1);
`endif
        ts_ready = 1'b1;
        cyc();
        chk("bp_out25", ts_data, 25);
        cyc();
        chk("bp_drained", 64'(ts_valid), 0);
        chk("bp_ovf_sticky", 64'(overflow), 64'b0010);
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        chk("bp_ovf_clr", 64'(overflow), 0);
`ifdef TS_CTRL_DROP_CNT_EN
        chk("bp_drop_clr", 64'(drop_cnt), 0);
`endif

        // Capture on the same edge slot 3 is granted
        ts_ready = 1'b0;
        req = 4'b1000; cyc(); req = '0;
        cyc();
        chk("cdg_out30", ts_data, 30);
        load(40);
        req = 4'b1000; cyc(); req = '0;
        chk("cdg_pend", 64'(pending), 64'b1000);
        load(45);
        ts_ready = 1'b1; req = 4'b1000;
        cyc();
        ts_ready = 1'b0; req = '0;
        chk("cdg_out40", ts_data, 40);
        chk("cdg_src3", 64'(ts_src), 3);
        chk("cdg_pend_kept", 64'(pending), 64'b1000);
        chk("cdg_no_ovf", 64'(overflow), 0);
        ts_ready = 1'b1;
        cyc();
        chk("cdg_out45", ts_data, 45);
        cyc();
        chk("cdg_drained", 64'(ts_valid), 0);

        // Reset mid-drain, with a req in the reset cycle
        ts_ready = 1'b0; cnt_en = 1'b1;
        req = 4'b1111; cyc(); req = '0;
        cyc();
        chk("mid_valid", 64'(ts_valid), 1);
        chk("mid_pend", 64'(pending), 64'b1110);
        reset = 1'b1; req = 4'b1111;
        cyc();
        reset = 1'b0; req = '0; cnt_en = 1'b0;
        chk("mid_rst_valid", 64'(ts_valid), 0);
        chk("mid_rst_pend", 64'(pending), 0);
        chk("mid_rst_cur", cur_time, 0);
        cyc();
        chk("mid_req_ignored", 64'(pending), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
